pwr_domain_agent: RTL and testbench
===================================

Name: pwr_domain_agent

Overview:
Domain-side responder to the per-domain power-sequencer handshake (iso_en / rst_assert / pwr_sw_en / clk_en in, domain_idle out). One instance sits at the always-on boundary of each switchable domain.
- Confirms switch-chain ramp via ack.
- Generates the delayed domain reset release.
- Gates and drains outstanding fabric transactions before reporting idle.
- Flags protocol violations.

Parameters:
- OUTST_MAX, 15, max outstanding transactions tracked; counter width $clog2(OUTST_MAX+1).
- ACK_TIMEOUT, 1024, cycles allowed in A_RAMP for pwr_sw_ack_i before fault.
- RST_REL_DLY, 8, cycles between handshake release and dom_rst_n_o deassertion (1..255).

Ports:
- clk  in  1  always-on clock.
- rst_n  in  1  asynchronous active-low reset.
- pwr_sw_en_i  in  1  power switch enable from sequencer.
- iso_en_i  in  1  isolation request from sequencer.
- rst_assert_i  in  1  domain reset request from sequencer.
- clk_en_i  in  1  domain clock enable from sequencer.
- pwr_sw_ack_i  in  1  switch-chain ramp-complete ack (sync to clk).
- domain_idle_o  out  1  domain quiesced/unpowered, to sequencer.
- dom_rst_n_o  out  1  active-low reset to domain logic.
- txn_allow_o  out  1  fabric may issue new transactions into domain.
- txn_issue_i  in  1  one transaction issued this cycle.
- txn_done_i  in  1  one transaction completed this cycle.
- ret_save_o  out  1  retention save request.
- ret_save_done_i  in  1  retention save complete.
- ret_restore_o  out  1  retention restore request.
- ret_restore_done_i  in  1  retention restore complete.
- agent_err_o  out  1  sticky protocol fault.

Behaviour:
- Single clock; reset is asynchronous, active-low (clk, rst_n).
- All outputs are decoded from registered state and counters; no input-to-output combinational paths.
- Reset state A_OFF. Reset outputs: domain_idle_o=1, dom_rst_n_o=0, txn_allow_o=0, ret_*_o=0, agent_err_o=0. Counters cleared.
- Outstanding counter cnt:
  - +1 on issue, -1 on done; issue and done in the same cycle leaves cnt unchanged.
  - issue while txn_allow_o=0 -> A_ERR; cnt unchanged.
  - done while cnt==0 -> A_ERR; cnt unchanged.
  - No wrap, ever.
- A_OFF: idle=1, rst low. pwr_sw_en_i=1 -> A_RAMP, tmr=0.
- A_RAMP: idle=0.
  - pwr_sw_ack_i=1 -> A_POWERED.
  - pwr_sw_en_i=0 -> A_OFF.
  - tmr==ACK_TIMEOUT-1 with no ack -> A_ERR; otherwise tmr++.
- A_POWERED:
  - Holds tmr=0 until clk_en_i=1 && !iso_en_i && !rst_assert_i, then tmr++.
  - tmr==RST_REL_DLY -> A_RESTORE (feature on) or A_ACTIVE.
  - Any handshake input dropping mid-count restarts tmr=0.
  - pwr_sw_en_i=0 -> A_OFF.
- A_ACTIVE: dom_rst_n_o=1; txn_allow_o = (cnt<OUTST_MAX).
  - iso_en_i || rst_assert_i -> A_DRAIN; txn_allow_o falls the next cycle.
  - Same-cycle issue is still legal and counted.
- A_DRAIN: txn_allow_o=0, dom_rst_n_o=1.
  - cnt==0 (after this cycle's update) -> A_SAVE (feature on) or A_IDLE.
  - Both iso_en_i and rst_assert_i deasserted -> A_ACTIVE (pwrdn request withdrawn); this has priority over the cnt==0 exit.
- A_IDLE: domain_idle_o=1, dom_rst_n_o=0.
  - pwr_sw_en_i=0 -> A_OFF.
  - iso/rst both deasserted with pwr_sw_en_i=1 -> A_POWERED (full reset-release replay).
- Power-loss rule, in every powered state (A_POWERED, A_RESTORE, A_ACTIVE, A_DRAIN, A_SAVE): pwr_sw_ack_i falling while pwr_sw_en_i=1 -> A_ERR.
- A_ERR:
  - Outputs: agent_err_o=1, domain_idle_o=1 (lets sequencer cut power), dom_rst_n_o=0, txn_allow_o=0.
  - Sticky until rst_n.
- Priority within a cycle: A_ERR conditions > pwr_sw_en_i drop > state-specific transitions.

Optional Feature:
PWR_DOMAIN_AGENT_RETENTION_EN
- Defined:
  - A_SAVE: ret_save_o=1 until ret_save_done_i, then A_IDLE. pwr_sw_en_i drop while waiting -> A_ERR.
  - A_RESTORE: dom_rst_n_o=1, txn_allow_o=0, ret_restore_o=1 until ret_restore_done_i, then A_ACTIVE.
- Undefined:
  - States are absent; ret_save_o and ret_restore_o are tied 0; done inputs are ignored.
  - Ports remain present.

Decomposition:
- Package pwr_agent_pkg holds:
  - agent state enum (A_OFF, A_RAMP, A_POWERED, A_RESTORE, A_ACTIVE, A_DRAIN, A_SAVE, A_IDLE, A_ERR), 4-bit encoding.
  - Default timing constants shared with the sequencer integration.
- One sub-module: pwr_agent_txn_cnt. It is the saturating-checked outstanding counter with an overflow/underflow error output.

Test Plan:
- Nominal up:
  - pwr_sw_en=1, ack after 20 cycles, clk_en=1 & iso/rst=0 -> dom_rst_n_o rises exactly RST_REL_DLY=8 cycles later.
  - txn_allow_o=1 the same cycle.
- Drain:
  - 3 outstanding, assert iso+rst -> txn_allow_o=0 next cycle.
  - 3 dones -> domain_idle_o=1 the cycle after the last done.
  - Drop pwr_sw_en -> A_OFF.
- Abort: in A_DRAIN with cnt=2, deassert iso+rst -> A_ACTIVE, txn_allow_o=1, domain_idle_o stays 0.
- Timeout: pwr_sw_en=1, no ack -> agent_err_o=1 after 1024 cycles; sticky; cleared only by rst_n.
- Counter boundaries:
  - 15 issues -> txn_allow_o=0.
  - Simultaneous issue+done at cnt=15 -> cnt stays 15, no error.
  - done at cnt=0 -> agent_err_o=1.
- Retention (macro on):
  - Drain to cnt=0 -> ret_save_o=1; ret_save_done after 5 cycles -> domain_idle_o=1.
  - Power-up -> ret_restore_o=1 with txn_allow_o=0 until ret_restore_done.

Source files
------------

// File: rtl/pwr_agent_pkg.sv
// Shared state encoding and default timing constants for the
// domain-side power agent and its sequencer integration.
package pwr_agent_pkg;

    typedef enum logic [3:0] {
        A_OFF     = 4'd0,
        A_RAMP    = 4'd1,
        A_POWERED = 4'd2,
        A_RESTORE = 4'd3,
        A_ACTIVE  = 4'd4,
        A_DRAIN   = 4'd5,
        A_SAVE    = 4'd6,
        A_IDLE    = 4'd7,
        A_ERR     = 4'd8
    } agent_state_e;

    localparam int unsigned DEF_OUTST_MAX   = 15;
    localparam int unsigned DEF_ACK_TIMEOUT = 1024;
    localparam int unsigned DEF_RST_REL_DLY = 8;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwr_agent_txn_cnt.sv
// Outstanding-transaction counter; never wraps, flags illegal
// issue/done instead of counting them.
module pwr_agent_txn_cnt
    import pwr_agent_pkg::*;
#(
    parameter int unsigned OUTST_MAX = DEF_OUTST_MAX,
    parameter int unsigned CW        = $clog2(OUTST_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_i,
    input  logic          done_i,
    input  logic          allow_i,
    output logic [CW-1:0] cnt_o,
    output logic [CW-1:0] cnt_nxt_o,
    output logic          err_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          inc;
    logic          dec;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    always_comb begin
        inc   = issue_i & ~done_i;
        dec   = done_i & ~issue_i;
        full  = (cnt_q == CW'(OUTST_MAX));
        empty = (cnt_q == '0);
        ovf   = inc & (~allow_i | full);
        // a paired issue+done is net-zero unless neither half could be legal
        unf   = (dec & empty) | (issue_i & done_i & ~allow_i & empty);
        cnt_d = cnt_q;
        if (!(ovf | unf)) begin
            if (inc) begin
                cnt_d = cnt_q + CW'(1);
            end else if (dec) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign err_o     = ovf | unf;

endmodule

// File: rtl/pwr_domain_agent.sv
// Domain-side power handshake responder; retention save/restore states
// are built only when PWR_DOMAIN_AGENT_RETENTION_EN is defined.
module pwr_domain_agent
    import pwr_agent_pkg::*;
#(
    parameter int unsigned OUTST_MAX   = DEF_OUTST_MAX,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned RST_REL_DLY = DEF_RST_REL_DLY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_sw_en_i,
    input  logic iso_en_i,
    input  logic rst_assert_i,
    input  logic clk_en_i,
    input  logic pwr_sw_ack_i,
    output logic domain_idle_o,
    output logic dom_rst_n_o,
    output logic txn_allow_o,
    input  logic txn_issue_i,
    input  logic txn_done_i,
    output logic ret_save_o,
    input  logic ret_save_done_i,
    output logic ret_restore_o,
    input  logic ret_restore_done_i,
    output logic agent_err_o
);

    localparam int unsigned CW = $clog2(OUTST_MAX + 1);
    localparam int unsigned TW = $clog2(max_u(ACK_TIMEOUT, RST_REL_DLY) + 1);

`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
    localparam agent_state_e UP_ST = A_RESTORE;
    localparam agent_state_e DN_ST = A_SAVE;
`else
    localparam agent_state_e UP_ST = A_ACTIVE;
    localparam agent_state_e DN_ST = A_IDLE;
`endif

    agent_state_e  state_q;
    agent_state_e  state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic [TW-1:0] tmr_inc;
    logic          ack_q;
    logic          ack_d;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_err;
    logic          allow;

    logic          hs_ok;
    logic          pwrdn_rq;
    logic          ack_fall;
    logic          in_pwr;
    logic          ramp_to;
    logic          save_abt;
    logic          fault;

    pwr_agent_txn_cnt #(
        .OUTST_MAX (OUTST_MAX),
        .CW        (CW)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_i   (txn_issue_i),
        .done_i    (txn_done_i),
        .allow_i   (allow),
        .cnt_o     (cnt),
        .cnt_nxt_o (cnt_nxt),
        .err_o     (cnt_err)
    );

    assign allow    = (state_q == A_ACTIVE) && (cnt < CW'(OUTST_MAX));
    assign hs_ok    = clk_en_i & ~iso_en_i & ~rst_assert_i;
    assign pwrdn_rq = iso_en_i | rst_assert_i;
    assign ack_fall = ack_q & ~pwr_sw_ack_i & pwr_sw_en_i;
    assign tmr_inc  = tmr_q + TW'(1);
    assign ack_d    = pwr_sw_ack_i;
    assign in_pwr   = state_q inside {A_POWERED, A_RESTORE, A_ACTIVE,
                                      A_DRAIN, A_SAVE};
    assign ramp_to  = (state_q == A_RAMP) & ~pwr_sw_ack_i &
                      (tmr_q == TW'(ACK_TIMEOUT - 1));

`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
    assign save_abt = (state_q == A_SAVE) & ~pwr_sw_en_i;
`else
    logic unused_ret;
    assign save_abt   = 1'b0;
    assign unused_ret = ret_save_done_i ^ ret_restore_done_i;
`endif

    assign fault = cnt_err | (in_pwr & ack_fall) | ramp_to | save_abt;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (state_q == A_ERR) begin
            state_d = A_ERR;
        end else if (fault) begin
            state_d = A_ERR;
        end else if (!pwr_sw_en_i) begin
            state_d = A_OFF;
            tmr_d   = '0;
        end else begin
            case (state_q)
                A_OFF: begin
                    state_d = A_RAMP;
                    tmr_d   = '0;
                end
                A_RAMP: begin
                    if (pwr_sw_ack_i) begin
                        state_d = A_POWERED;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
                A_POWERED: begin
                    // release delay counts only while the handshake is steady
                    if (hs_ok) begin
                        tmr_d = tmr_inc;
                        if (tmr_inc == TW'(RST_REL_DLY)) begin
                            state_d = UP_ST;
                        end
                    end else begin
                        tmr_d = '0;
                    end
                end
`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
                A_RESTORE: begin
                    if (ret_restore_done_i) begin
                        state_d = A_ACTIVE;
                    end
                end
                A_SAVE: begin
                    if (ret_save_done_i) begin
                        state_d = A_IDLE;
                    end
                end
`endif
                A_ACTIVE: begin
                    if (pwrdn_rq) begin
                        state_d = A_DRAIN;
                    end
                end
                A_DRAIN: begin
                    if (!pwrdn_rq) begin
                        state_d = A_ACTIVE;
                    end else if (cnt_nxt == '0) begin
                        state_d = DN_ST;
                    end
                end
                A_IDLE: begin
                    if (!pwrdn_rq) begin
                        state_d = A_POWERED;
                        tmr_d   = '0;
                    end
                end
                default: begin
                    state_d = A_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= A_OFF;
            tmr_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        domain_idle_o = 1'b0;
        dom_rst_n_o   = 1'b0;
        ret_save_o    = 1'b0;
        ret_restore_o = 1'b0;
        agent_err_o   = 1'b0;
        case (state_q)
            A_OFF, A_IDLE: begin
                domain_idle_o = 1'b1;
            end
            A_ACTIVE, A_DRAIN: begin
                dom_rst_n_o = 1'b1;
            end
`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
            A_RESTORE: begin
                dom_rst_n_o   = 1'b1;
                ret_restore_o = 1'b1;
            end
            A_SAVE: begin
                dom_rst_n_o = 1'b1;
                ret_save_o  = 1'b1;
            end
`endif
            A_ERR: begin
                domain_idle_o = 1'b1;
                agent_err_o   = 1'b1;
            end
            default: begin
                domain_idle_o = 1'b0;
            end
        endcase
    end

    assign txn_allow_o = allow;

endmodule

// File: tb/tb_pwr_domain_agent.sv
// Bench for pwr_domain_agent: vector table, corner sequences and a
// randomized run against a behavioural model.
module tb_pwr_domain_agent;

    localparam int OM = 15;
    localparam int AT = 1024;
    localparam int RD = 8;
`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    // output vector order: idle, rst_n, allow, save, restore, err
    localparam logic [5:0] O_OFF  = 6'b100000;
    localparam logic [5:0] O_RAMP = 6'b000000;
    localparam logic [5:0] O_PWR  = 6'b000000;
    localparam logic [5:0] O_ACT  = 6'b011000;
    localparam logic [5:0] O_ACTF = 6'b010000;
    localparam logic [5:0] O_DRN  = 6'b010000;
    localparam logic [5:0] O_IDLE = 6'b100000;
    localparam logic [5:0] O_SAVE = 6'b010100;
    localparam logic [5:0] O_REST = 6'b010010;
    localparam logic [5:0] O_ERR  = 6'b100001;

    localparam int DOWN = 0, RAMPING = 1, WAITREL = 2, RESTORING = 3;
    localparam int RUN = 4, DRAINING = 5, SAVING = 6, PARKED = 7;
    localparam int FAULT = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en, iso, rsta, cke, ack, iss, dn, rsd, rrd;
    logic idle, rstn, allow, save, rest, err;
    logic [5:0] ov;

    int n_pass = 0;
    int n_tot  = 0;

    int m_ph, m_cnt, m_age, m_rel;
    bit m_pack;

    typedef struct {
        int         n;
        logic [8:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    assign ov = {idle, rstn, allow, save, rest, err};

    pwr_domain_agent #(
        .OUTST_MAX   (OM),
        .ACK_TIMEOUT (AT),
        .RST_REL_DLY (RD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pwr_sw_en_i        (en),
        .iso_en_i           (iso),
        .rst_assert_i       (rsta),
        .clk_en_i           (cke),
        .pwr_sw_ack_i       (ack),
        .domain_idle_o      (idle),
        .dom_rst_n_o        (rstn),
        .txn_allow_o        (allow),
        .txn_issue_i        (iss),
        .txn_done_i         (dn),
        .ret_save_o         (save),
        .ret_save_done_i    (rsd),
        .ret_restore_o      (rest),
        .ret_restore_done_i (rrd),
        .agent_err_o        (err)
    );

    function automatic vec_t mk(input int n, input logic [8:0] i,
                                input logic [5:0] e);
        vec_t v;
        v.n   = n;
        v.in  = i;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (idle,rstn,allow,save,rest,err)",
                     nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {en, iso, rsta, cke, ack, iss, dn, rsd, rrd} = 9'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic bring_up();
        do_reset();
        {en, iso, rsta, cke, ack, iss, dn, rsd, rrd} = 9'b100100001;
        cyc();
        ack = 1'b1;
        repeat (RET ? 10 : 9) cyc();
        chk("bring_up", ov, O_ACT);
    endtask

    function automatic logic [5:0] m_out();
        case (m_ph)
            DOWN, PARKED:  return 6'b100000;
            RUN:           return {2'b01, m_cnt < OM, 3'b000};
            DRAINING:      return 6'b010000;
            SAVING:        return 6'b010100;
            RESTORING:     return 6'b010010;
            FAULT:         return 6'b100001;
            default:       return 6'b000000;
        endcase
    endfunction

    task automatic m_reset();
        m_ph   = DOWN;
        m_cnt  = 0;
        m_age  = 0;
        m_rel  = 0;
        m_pack = 1'b0;
    endtask

    task automatic m_step();
        bit alw, bad, pwr;
        alw = (m_ph == RUN) && (m_cnt < OM);
        bad = 1'b0;
        if (iss && !dn && !alw) bad = 1'b1;
        if (dn && !iss && m_cnt == 0) bad = 1'b1;
        if (iss && dn && !alw && m_cnt == 0) bad = 1'b1;
        if (!bad) m_cnt = m_cnt + int'(iss) - int'(dn);
        pwr = m_ph inside {WAITREL, RESTORING, RUN, DRAINING, SAVING};
        if (m_ph == FAULT) begin
            m_ph = FAULT;
        end else if (bad || (pwr && m_pack && !ack && en) ||
                     (m_ph == RAMPING && !ack && m_age == AT - 1) ||
                     (m_ph == SAVING && !en)) begin
            m_ph = FAULT;
        end else if (!en) begin
            m_ph = DOWN;
        end else begin
            case (m_ph)
                DOWN: begin
                    m_ph  = RAMPING;
                    m_age = 0;
                end
                RAMPING: begin
                    if (ack) begin
                        m_ph  = WAITREL;
                        m_rel = 0;
                    end else begin
                        m_age++;
                    end
                end
                WAITREL: begin
                    if (cke && !iso && !rsta) begin
                        m_rel++;
                        if (m_rel == RD) m_ph = RET ? RESTORING : RUN;
                    end else begin
                        m_rel = 0;
                    end
                end
                RESTORING: if (rrd) m_ph = RUN;
                RUN:       if (iso || rsta) m_ph = DRAINING;
                DRAINING: begin
                    if (!iso && !rsta) m_ph = RUN;
                    else if (m_cnt == 0) m_ph = RET ? SAVING : PARKED;
                end
                SAVING:    if (rsd) m_ph = PARKED;
                PARKED: begin
                    if (!iso && !rsta) begin
                        m_ph  = WAITREL;
                        m_rel = 0;
                    end
                end
                default:   m_ph = FAULT;
            endcase
        end
        m_pack = ack;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit req;
        bit alw;

        do_reset();
        chk("reset", ov, O_OFF);

        tbl[0]  = mk(2,  9'b011000000, O_OFF);
        tbl[1]  = mk(20, 9'b100100000, O_RAMP);
        tbl[2]  = mk(8,  9'b100110000, O_PWR);
        tbl[3]  = mk(1,  9'b100110000, RET ? O_REST : O_ACT);
        tbl[4]  = mk(1,  9'b100110001, O_ACT);
        tbl[5]  = mk(3,  9'b100111000, O_ACT);
        tbl[6]  = mk(1,  9'b111110000, O_DRN);
        tbl[7]  = mk(2,  9'b111110100, O_DRN);
        tbl[8]  = mk(1,  9'b111110100, RET ? O_SAVE : O_IDLE);
        tbl[9]  = mk(4,  9'b111110000, RET ? O_SAVE : O_IDLE);
        tbl[10] = mk(1,  9'b111110010, O_IDLE);
        tbl[11] = mk(2,  9'b011000000, O_OFF);

        foreach (tbl[i]) begin
            {en, iso, rsta, cke, ack, iss, dn, rsd, rrd} = tbl[i].in;
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc();
                chk($sformatf("vec%0d.%0d", i, k), ov, tbl[i].exp);
            end
        end

        // abort a drain, then underflow, sticky error, async clear
        bring_up();
        iss = 1'b1;
        cyc();
        cyc();
        iso = 1'b1;
        rsta = 1'b1;
        cyc();
        chk("abort_drain", ov, O_DRN);
        iss = 1'b0;
        dn = 1'b1;
        cyc();
        chk("abort_drain_cnt2", ov, O_DRN);
        dn = 1'b0;
        iso = 1'b0;
        rsta = 1'b0;
        cyc();
        chk("abort_active", ov, O_ACT);
        dn = 1'b1;
        cyc();
        cyc();
        chk("abort_drain_to_0", ov, O_ACT);
        cyc();
        chk("underflow", ov, O_ERR);
        dn = 1'b0;
        en = 1'b0;
        repeat (5) cyc();
        chk("err_sticky", ov, O_ERR);
        do_reset();
        chk("err_cleared", ov, O_OFF);

        // ack timeout
        en = 1'b1;
        cke = 1'b1;
        repeat (AT) cyc();
        chk("timeout_pre", ov, O_RAMP);
        cyc();
        chk("timeout", ov, O_ERR);
        ack = 1'b1;
        repeat (3) cyc();
        chk("timeout_sticky", ov, O_ERR);
        do_reset();
        chk("timeout_cleared", ov, O_OFF);

        // counter saturation boundaries
        bring_up();
        iss = 1'b1;
        for (int i = 1; i <= OM; i++) begin
            cyc();
            chk($sformatf("fill%0d", i), {5'b0, allow}, {5'b0, i < OM});
        end
        dn = 1'b1;
        cyc();
        chk("iss_done_full", ov, O_ACTF);
        iss = 1'b0;
        cyc();
        chk("done_from_full", ov, O_ACT);
        iss = 1'b1;
        dn = 1'b0;
        cyc();
        chk("refill", ov, O_ACTF);
        cyc();
        chk("overflow", ov, O_ERR);

        // supply collapse while powered
        bring_up();
        ack = 1'b0;
        cyc();
        chk("pwr_loss", ov, O_ERR);

        bring_up();
        rst_n = 1'b0;
        #1;
        chk("async_reset", ov, O_OFF);

`ifdef PWR_DOMAIN_AGENT_RETENTION_EN
        do_reset();
        en = 1'b1;
        cke = 1'b1;
        cyc();
        ack = 1'b1;
        repeat (9) cyc();
        chk("restore", ov, O_REST);
        repeat (3) cyc();
        chk("restore_hold", ov, O_REST);
        rrd = 1'b1;
        cyc();
        chk("restore_done", ov, O_ACT);
        rrd = 1'b0;
        iso = 1'b1;
        rsta = 1'b1;
        cyc();
        chk("save_drain", ov, O_DRN);
        cyc();
        chk("save", ov, O_SAVE);
        en = 1'b0;
        cyc();
        chk("save_abort", ov, O_ERR);
`endif

        for (int s = 0; s < 30; s++) begin
            do_reset();
            m_reset();
            req = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(99) == 0) en = ~en;
                if (en && !ack && $urandom_range(7) == 0) ack = 1'b1;
                else if (!en && $urandom_range(1) == 0) ack = 1'b0;
                else if (ack && $urandom_range(799) == 0) ack = 1'b0;
                cke = ($urandom_range(15) != 0);
                if ($urandom_range(39) == 0) req = ~req;
                iso = req;
                rsta = req;
                if ($urandom_range(31) == 0) iso = ~iso;
                alw = (m_ph == RUN) && (m_cnt < OM);
                iss = alw ? ($urandom_range(2) == 0) : ($urandom_range(499) == 0);
                dn = (m_cnt > 0) ? ($urandom_range(2) == 0)
                                 : ($urandom_range(499) == 0);
                rsd = ($urandom_range(3) == 0);
                rrd = ($urandom_range(3) == 0);
                @(posedge clk);
                m_step();
                #1;
                chk($sformatf("rand s%0d c%0d", s, c), ov, m_out());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
